// File: rtl/ro_cache_pkg.sv
// -----------------------------------------------------------------------------
// ro_cache_pkg
// Shared types and constants for the read-only cache front end.
//   ro_cache_arb_state_t : arbiter/sequencer FSM states
//   RO_CACHE_STAT_WIDTH  : width of each per-requester grant counter
// -----------------------------------------------------------------------------
package ro_cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } ro_cache_arb_state_t;

  localparam int RO_CACHE_STAT_WIDTH = 16;

endpackage

// File: rtl/ro_cache_rr_pick.sv
// -----------------------------------------------------------------------------
// ro_cache_rr_pick
// Combinational rotating-priority picker. The search starts one position after
// the last winner and wraps, so each requester is at most NUM_REQ-1 grants
// away from being served.
// Ports:
//   req     in  NUM_REQ  request vector
//   last    in  IDX_W    index of the previous winner
//   onehot  out NUM_REQ  one-hot winner (zero when no request)
//   idx     out IDX_W    winner index (zero when no request)
//   any     out 1        at least one request present
// -----------------------------------------------------------------------------
module ro_cache_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; otherwise a path that skips the assignment infers
  // a latch.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(last) + off) % NUM_REQ);
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ro_cache_arb.sv
// -----------------------------------------------------------------------------
// ro_cache_arb
// Round-robin arbiter and sequencer sharing the single cache read port among
// NUM_REQ requesters. One transaction at a time: IDLE accepts a winner, ISSUE
// presents the registered address to the cache, WAIT returns the response to
// the owning requester.
//
// Optional feature: define RO_CACHE_ARB_STATS_EN to enable saturating 16-bit
// per-requester grant counters; otherwise stat_grant_cnt is tied to zero.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/addr    per-requester request, address i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_ready         one-hot accept, only in IDLE
//   resp_valid/data   one-hot response strobe, shared data (zero when idle)
//   cache_req_*       request to the cache (registered address)
//   cache_resp_*      response from the cache
//   gnt_sel           registered one-hot grant, drives the cache slice mux
//   stat_grant_cnt    per-requester grant counters, requester i at [i*16 +: 16]
// -----------------------------------------------------------------------------
module ro_cache_arb
  import ro_cache_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]          req_addr,
  output logic [NUM_REQ-1:0]                     req_ready,
  output logic [NUM_REQ-1:0]                     resp_valid,
  output logic [DATA_WIDTH-1:0]                  resp_data,
  output logic                                   cache_req_valid,
  output logic [ADDR_WIDTH-1:0]                  cache_req_addr,
  input  logic                                   cache_req_ready,
  input  logic                                   cache_resp_valid,
  input  logic [DATA_WIDTH-1:0]                  cache_resp_data,
  output logic [NUM_REQ-1:0]                     gnt_sel,
  output logic [NUM_REQ*RO_CACHE_STAT_WIDTH-1:0] stat_grant_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);

  ro_cache_arb_state_t state_q, state_d;
  logic [IDX_W-1:0]      winner_q;
  logic [IDX_W-1:0]      last_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [NUM_REQ-1:0]    gnt_q;

  logic [NUM_REQ-1:0]    pick_onehot;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic                  accept;
  logic                  resp_fire;

  ro_cache_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req_valid),
    .last   (last_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign accept    = (state_q == IDLE) && pick_any;
  assign resp_fire = (state_q == WAIT) && cache_resp_valid;

  // Address of the winner, selected with the one-hot so no variable part-select
  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) pick_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_any)         state_d = ISSUE;
      ISSUE:   if (cache_req_ready)  state_d = WAIT;
      WAIT:    if (cache_resp_valid) state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // FSM: outputs. gnt_sel and cache_req_addr come straight from flops so the
  // cache mux select has no combinational path from the requester side.
  always_comb begin
    req_ready       = (state_q == IDLE) ? pick_onehot : '0;
    cache_req_valid = (state_q == ISSUE);
    cache_req_addr  = addr_q;
    gnt_sel         = gnt_q;
    resp_valid      = resp_fire ? gnt_q : '0;
    resp_data       = resp_fire ? cache_resp_data : '0;
  end

  // ---------------------------------------------------------------------------
  // Transaction registers. Reset also aborts any in-flight transaction: gnt_q
  // clears, so a late cache response finds the FSM in IDLE and is dropped.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      winner_q <= '0;
      last_q   <= IDX_W'(NUM_REQ - 1);
      addr_q   <= '0;
      gnt_q    <= '0;
    end else begin
      if (accept) begin
        winner_q <= pick_idx;
        addr_q   <= pick_addr;
        gnt_q    <= pick_onehot;
      end
      if (resp_fire) begin
        last_q <= winner_q;
        gnt_q  <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Grant statistics
  // ---------------------------------------------------------------------------
`ifdef RO_CACHE_ARB_STATS_EN
  logic [RO_CACHE_STAT_WIDTH-1:0] cnt_q [NUM_REQ];

  // NOTE: the counter array is architectural state visible on a port, so it
  // is reset explicitly; it is flops, not a RAM, and reset costs nothing extra.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && pick_onehot[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_grant_cnt[g*RO_CACHE_STAT_WIDTH +: RO_CACHE_STAT_WIDTH] = cnt_q[g];
  end
`else
  assign stat_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_ro_cache_arb.sv
// -----------------------------------------------------------------------------
// tb_ro_cache_arb
// Self-checking bench for ro_cache_arb. A behavioural model (rotating search
// from the last winner, per-requester grant tallies) supplies all expected
// values. Honours RO_CACHE_ARB_STATS_EN for the counter expectations.
// -----------------------------------------------------------------------------
module tb_ro_cache_arb;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      resp_valid;
  logic [DW-1:0]     resp_data;
  logic              cache_req_valid;
  logic [AW-1:0]     cache_req_addr;
  logic              cache_req_ready;
  logic              cache_resp_valid;
  logic [DW-1:0]     cache_resp_data;
  logic [N-1:0]      gnt_sel;
  logic [N*SW-1:0]   stat_grant_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int model_last;
  int exp_cnt [N];

  always #5 clk = ~clk;

  ro_cache_arb #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_addr         (req_addr),
    .req_ready        (req_ready),
    .resp_valid       (resp_valid),
    .resp_data        (resp_data),
    .cache_req_valid  (cache_req_valid),
    .cache_req_addr   (cache_req_addr),
    .cache_req_ready  (cache_req_ready),
    .cache_resp_valid (cache_resp_valid),
    .cache_resp_data  (cache_resp_data),
    .gnt_sel          (gnt_sel),
    .stat_grant_cnt   (stat_grant_cnt)
  );

  // First valid requester searching upward from last+1, wrapping.
  function automatic int rr_model(input logic [N-1:0] mask, input int last);
    for (int off = 1; off <= N; off++) begin
      if (mask[(last + off) % N]) return (last + off) % N;
    end
    return -1;
  endfunction

  function automatic int exp_stat(input int i);
`ifdef RO_CACHE_ARB_STATS_EN
    return (exp_cnt[i] > 16'hFFFF) ? 16'hFFFF : exp_cnt[i];
`else
    return (i < 0) ? 1 : 0;
`endif
  endfunction

  function automatic logic [N*AW-1:0] rand_addrs();
    logic [N*AW-1:0] a;
    for (int i = 0; i < N; i++) a[i*AW +: AW] = $urandom;
    return a;
  endfunction

  task automatic model_grant(input int w);
    model_last = w;
    exp_cnt[w]++;
  endtask

  task automatic apply_reset();
    rst              = 1'b1;
    req_valid        = '0;
    req_addr         = '0;
    cache_req_ready  = 1'b0;
    cache_resp_valid = 1'b0;
    cache_resp_data  = '0;
    repeat (2) @(negedge clk);
    rst        = 1'b0;
    model_last = N - 1;
    for (int i = 0; i < N; i++) exp_cnt[i] = 0;
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    req_valid        = '0;
    cache_req_ready  = 1'b0;
    cache_resp_valid = 1'b0;
  endtask

  // Drives one full transaction starting in an IDLE cycle; every wait is
  // bounded by the requested delays. o_err counts protocol deviations seen
  // along the way (outputs not stable in ISSUE, req_ready outside IDLE, etc).
  task automatic do_txn(input logic [N-1:0] vmask, input logic [N*AW-1:0] addrs,
                        input int rdy_dly, input int rsp_dly, input logic [DW-1:0] data,
                        output logic [N-1:0] o_ready, output logic [AW-1:0] o_addr,
                        output logic [N-1:0] o_gnt, output logic [N-1:0] o_resp,
                        output logic [DW-1:0] o_data, output int o_err);
    o_err  = 0;
    o_addr = '0;
    o_gnt  = '0;
    o_resp = '0;
    o_data = '0;
    @(negedge clk);
    req_valid        = vmask;
    req_addr         = addrs;
    cache_req_ready  = 1'b0;
    cache_resp_valid = 1'b0;
    #1;
    o_ready = req_ready;
    if (gnt_sel !== '0 || cache_req_valid !== 1'b0 || resp_valid !== '0) o_err++;
    if (req_ready === '0) return;
    for (int k = 0; k <= rdy_dly; k++) begin
      @(negedge clk);
      cache_req_ready = (k == rdy_dly);
      #1;
      if (k == 0) begin
        o_addr = cache_req_addr;
        o_gnt  = gnt_sel;
      end
      if (cache_req_valid !== 1'b1 || cache_req_addr !== o_addr || gnt_sel !== o_gnt ||
          req_ready !== '0 || resp_valid !== '0) o_err++;
    end
    for (int k = 0; k <= rsp_dly; k++) begin
      @(negedge clk);
      cache_req_ready  = 1'b0;
      cache_resp_valid = (k == rsp_dly);
      cache_resp_data  = (k == rsp_dly) ? data : DW'($urandom);
      #1;
      if (cache_req_valid !== 1'b0 || req_ready !== '0 || gnt_sel !== o_gnt) o_err++;
      if (k < rsp_dly && resp_valid !== '0) o_err++;
    end
    o_resp = resp_valid;
    o_data = resp_data;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    apply_reset();
    #1;
    total++; if (req_ready !== '0 || resp_valid !== '0 || gnt_sel !== '0) begin
      bad++; $display("FAIL reset_vectors: ready=%b resp=%b gnt=%b want all 0", req_ready, resp_valid, gnt_sel);
    end
    total++; if (cache_req_valid !== 1'b0 || cache_req_addr !== '0 || resp_data !== '0) begin
      bad++; $display("FAIL reset_cache: valid=%b addr=%h data=%h want 0", cache_req_valid, cache_req_addr, resp_data);
    end
    total++; if (stat_grant_cnt !== '0) begin
      bad++; $display("FAIL reset_stats: got %h want 0", stat_grant_cnt);
    end
  endtask

  task automatic test_single();
    logic [N*AW-1:0] a;
    logic [N-1:0] rdy, gnt, rsp;
    logic [AW-1:0] ad;
    logic [DW-1:0] d;
    int err;
    apply_reset();
    a = rand_addrs();
    a[2*AW +: AW] = 32'h100;
    do_txn(4'b0100, a, 0, 1, 32'hDEADBEEF, rdy, ad, gnt, rsp, d, err);
    model_grant(2);
    total++; if (rdy !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b want 0100", rdy); end
    total++; if (gnt !== 4'b0100 || ad !== 32'h100) begin
      bad++; $display("FAIL single_issue: gnt=%b addr=%h want 0100 00000100", gnt, ad);
    end
    total++; if (rsp !== 4'b0100 || d !== 32'hDEADBEEF) begin
      bad++; $display("FAIL single_resp: resp=%b data=%h want 0100 deadbeef", rsp, d);
    end
    total++; if (err !== 0) begin bad++; $display("FAIL single_protocol: errs=%0d want 0", err); end
    idle_inputs();
    #1;
    total++; if (gnt_sel !== '0 || cache_req_valid !== 1'b0 || resp_valid !== '0) begin
      bad++; $display("FAIL single_idle: gnt=%b creq=%b resp=%b want 0", gnt_sel, cache_req_valid, resp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [N*AW-1:0] a;
    logic [N-1:0] rdy, gnt, rsp;
    logic [AW-1:0] ad;
    logic [DW-1:0] d, dat;
    int err, w;
    apply_reset();
    for (int t = 0; t < 8; t++) begin
      a   = rand_addrs();
      dat = $urandom;
      do_txn('1, a, 0, 0, dat, rdy, ad, gnt, rsp, d, err);
      w = t % N;
      total++; if (rdy !== N'(1 << w) || ad !== a[w*AW +: AW] || rsp !== N'(1 << w) ||
                   d !== dat || err !== 0) begin
        bad++; $display("FAIL rr_order[%0d]: ready=%b addr=%h resp=%b errs=%0d want ready=%b addr=%h",
                        t, rdy, ad, rsp, err, N'(1 << w), a[w*AW +: AW]);
      end
      model_grant(w);
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    logic [N*AW-1:0] a;
    logic [N-1:0] rdy, gnt, rsp;
    logic [AW-1:0] ad;
    logic [DW-1:0] d, dat;
    int err, w;
    a   = rand_addrs();
    dat = $urandom;
    w   = rr_model('1, model_last);
    do_txn('1, a, 5, 2, dat, rdy, ad, gnt, rsp, d, err);
    model_grant(w);
    total++; if (err !== 0) begin bad++; $display("FAIL stall_stable: errs=%0d want 0", err); end
    total++; if (gnt !== N'(1 << w) || ad !== a[w*AW +: AW] || rsp !== N'(1 << w) || d !== dat) begin
      bad++; $display("FAIL stall_txn: gnt=%b addr=%h resp=%b data=%h want %b %h %b %h",
                      gnt, ad, rsp, d, N'(1 << w), a[w*AW +: AW], N'(1 << w), dat);
    end
    idle_inputs();
  endtask

  task automatic test_reset_in_wait();
    logic [N*AW-1:0] a;
    logic [N-1:0] rdy, gnt, rsp;
    logic [AW-1:0] ad;
    logic [DW-1:0] d, dat;
    int err;
    a = rand_addrs();
    @(negedge clk);
    req_valid = 4'b0010;
    req_addr  = a;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rstwait_accept: got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid       = '0;
    cache_req_ready = 1'b1;
    @(negedge clk);
    cache_req_ready = 1'b0;
    rst             = 1'b1;
    @(negedge clk);
    rst              = 1'b0;
    cache_resp_valid = 1'b1;
    cache_resp_data  = $urandom;
    #1;
    model_last = N - 1;
    for (int i = 0; i < N; i++) exp_cnt[i] = 0;
    total++; if (resp_valid !== '0 || gnt_sel !== '0 || cache_req_valid !== 1'b0) begin
      bad++; $display("FAIL rstwait_drop: resp=%b gnt=%b creq=%b want 0", resp_valid, gnt_sel, cache_req_valid);
    end
    dat = $urandom;
    do_txn('1, a, 0, 0, dat, rdy, ad, gnt, rsp, d, err);
    model_grant(0);
    total++; if (rdy !== 4'b0001 || rsp !== 4'b0001 || err !== 0) begin
      bad++; $display("FAIL rstwait_prio: ready=%b resp=%b errs=%0d want 0001 0001 0", rdy, rsp, err);
    end
    idle_inputs();
  endtask

  task automatic test_resp_in_idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_valid        = '0;
      cache_resp_valid = 1'b1;
      cache_resp_data  = $urandom;
      #1;
      total++; if (resp_valid !== '0 || gnt_sel !== '0) begin
        bad++; $display("FAIL idle_resp[%0d]: resp=%b gnt=%b want 0", k, resp_valid, gnt_sel);
      end
    end
    idle_inputs();
  endtask

  task automatic test_stats();
    logic [N*AW-1:0] a;
    logic [N-1:0] rdy, gnt, rsp;
    logic [AW-1:0] ad;
    logic [DW-1:0] d;
    int err;
    apply_reset();
    for (int t = 0; t < 3; t++) begin
      a = rand_addrs();
      do_txn(4'b0010, a, t, 0, DW'($urandom), rdy, ad, gnt, rsp, d, err);
      model_grant(1);
    end
    idle_inputs();
    for (int i = 0; i < N; i++) begin
      total++; if (int'(stat_grant_cnt[i*SW +: SW]) !== exp_stat(i)) begin
        bad++; $display("FAIL stats[%0d]: got %0d want %0d", i, stat_grant_cnt[i*SW +: SW], exp_stat(i));
      end
    end
  endtask

  task automatic test_random();
    logic [N*AW-1:0] a;
    logic [N-1:0] rdy, gnt, rsp, mask;
    logic [AW-1:0] ad;
    logic [DW-1:0] d, dat;
    int err, w;
    for (int t = 0; t < 40; t++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      a    = rand_addrs();
      dat  = $urandom;
      w    = rr_model(mask, model_last);
      do_txn(mask, a, $urandom_range(0, 3), $urandom_range(0, 3), dat, rdy, ad, gnt, rsp, d, err);
      total++; if (rdy !== N'(1 << w) || gnt !== N'(1 << w) || ad !== a[w*AW +: AW] ||
                   rsp !== N'(1 << w) || d !== dat || err !== 0) begin
        bad++; $display("FAIL random[%0d]: mask=%b ready=%b gnt=%b addr=%h resp=%b data=%h errs=%0d want w=%0d addr=%h data=%h",
                        t, mask, rdy, gnt, ad, rsp, d, err, w, a[w*AW +: AW], dat);
      end
      model_grant(w);
      if ($urandom_range(0, 3) == 0) idle_inputs();
    end
    idle_inputs();
    for (int i = 0; i < N; i++) begin
      total++; if (int'(stat_grant_cnt[i*SW +: SW]) !== exp_stat(i)) begin
        bad++; $display("FAIL random_stats[%0d]: got %0d want %0d", i, stat_grant_cnt[i*SW +: SW], exp_stat(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_reset_in_wait();
    test_resp_in_idle();
    test_random();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
